pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and flush controller for the five-stage IF/ID/EX/MEM/WB pipeline. It generalises the fixed stage passthroughs: it tracks in-flight destination registers for EX, MEM and WB, and produces load-use stalls, branch flushes and registered forwarding selects. It also latches halt retirement and keeps saturating stall/flush statistics. It sits beside the stage modules in the CPU top and drives their hold and bubble controls.

Parameters:
REG_AW, 4, register-address width; register file has 2**REG_AW entries.
ZERO_REG, 1, if 1 then register 0 is hard-wired zero and never causes a hazard or a forward.
CNT_W, 16, width of the stall and flush statistics counters.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_src0, id_src1  input  REG_AW  ID source register addresses
id_use0, id_use1  input  1  corresponding source is read
id_dst  input  REG_AW  ID destination register
id_we  input  1  ID instruction writes the register file
id_load  input  1  ID instruction is a memory read
id_hlt  input  1  ID instruction is HLT
branch_taken  input  1  branch resolved taken in MEM this cycle
mem_stall  input  1  data memory busy; freeze whole pipe
stall_if  output  1  hold PC and IF/ID register
flush_if_id  output  1  replace IF/ID contents with a bubble
bubble_ex  output  1  ID/EX latches a bubble this edge
fwd0_sel, fwd1_sel  output  2  EX operand source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
halted  output  1  sticky: HLT has retired
stall_cnt, flush_cnt  output  CNT_W  saturating statistics

Behaviour:
- Internal tracker regs ex_, mem_, wb_: {valid, dst, we, load, hlt}. Reset clears every valid.
- Reset values: all outputs 0. Reset mid-operation discards all in-flight state on that edge.
- Each source hit is computed as follows. Hit on stage S = use & S.valid & S.we & (src == S.dst). If ZERO_REG=1, src==0 never hits.
- load_use = id_valid & ex.valid & ex.load & ex.we & (hit0_ex | hit1_ex).
- Combinational outputs:
  - stall_if = mem_stall | load_use | hlt_seen.
  - flush_if_id = branch_taken & ~mem_stall.
  - bubble_ex = ~mem_stall & (load_use | branch_taken | ~id_valid).
- Edge update when mem_stall=1: all tracker regs, fwd selects and counters hold. branch_taken is ignored and must be re-presented.
- Edge update when mem_stall=0:
  - wb <= mem.
  - mem <= branch_taken ? bubble : ex. This squashes the wrong-path instruction in EX.
  - ex <= bubble_ex ? bubble : ID fields.
- fwd selects are registered and valid during the cycle the instruction is in EX.
  - fwdN_sel <= hitN_ex ? 01 : hitN_mem ? 10 : 00. The youngest producer wins.
  - If bubble_ex=1, the selects are 00.
- hlt_seen is set when id_valid & id_hlt is accepted into EX. It is sticky until rst and freezes fetch.
- halted is set on the edge wb.valid & wb.hlt. It is sticky until rst. A branch_taken that squashes the HLT in EX/MEM also clears hlt_seen.
- stall_cnt increments on each edge with load_use & ~mem_stall. flush_cnt increments on each edge with flush_if_id. Both saturate at 2**CNT_W-1 with no wrap.
- Simultaneous load_use and branch_taken: the flush wins. The bubble is inserted, stall_if stays 1 for that cycle, and only flush_cnt increments.
- Latency: hazard detection is same-cycle (0). Forward selects appear 1 edge after ID.

Test Plan:
- Forward from EX: ADD r3 then SUB r4,r3,r5 back-to-back. Required: fwd0_sel=01 while SUB is in EX, and no stall.
- Forward from MEM/WB: ADD r3; NOP; SUB r4,r3,r3. Required: fwd0_sel=fwd1_sel=10.
- Load-use: LW r2 then ADD r6,r2,r1. Required: stall_if=1 and bubble_ex=1 for exactly 1 cycle, then fwd0_sel=10 and stall_cnt=1.
- Zero register: ADD r0 then ADD r1,r0,r0 with ZERO_REG=1. Required: fwd selects 00 and no stall.
- Branch flush plus mem_stall: pulse branch_taken during mem_stall=1, then again with mem_stall=0. Required: no effect in the first case; in the second, flush_if_id=1, EX is squashed and flush_cnt=1.
- Halt: issue HLT. Required: stall_if stays high from the cycle after ID and halted rises 3 edges later. Then assert rst for 1 cycle. Required: halted=0, counters=0, fwd=00.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for the five-stage IF/ID/EX/MEM/WB pipeline.
// Tracks in-flight destinations, raises load-use stalls and branch flushes, and registers forward selects.
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 4,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src0,
  input  logic [REG_AW-1:0] id_src1,
  input  logic              id_use0,
  input  logic              id_use1,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              id_hlt,
  input  logic              branch_taken,
  input  logic              mem_stall,
  output logic              stall_if,
  output logic              flush_if_id,
  output logic              bubble_ex,
  output logic [1:0]        fwd0_sel,
  output logic [1:0]        fwd1_sel,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              we;
    logic              load;
    logic              hlt;
  } ex_trk_t;

  // Only forwarding and halt retirement look past EX, so MEM drops the load flag and WB keeps just HLT.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              we;
    logic              hlt;
  } mem_trk_t;

  ex_trk_t  ex_q;
  ex_trk_t  id_trk;
  mem_trk_t mem_q;
  logic     wb_hlt_q;
  logic     hlt_seen_q;

  logic hit0_ex, hit1_ex, hit0_mem, hit1_mem;
  logic load_use;
  logic [1:0] fwd0_nxt, fwd1_nxt;

  function automatic logic src_hit(input logic              rd,
                                   input logic [REG_AW-1:0] src,
                                   input logic              s_valid,
                                   input logic              s_we,
                                   input logic [REG_AW-1:0] s_dst);
    logic zero_src;
    zero_src = ZERO_REG && (src == '0);
    return rd && s_valid && s_we && (src == s_dst) && !zero_src;
  endfunction

  assign hit0_ex  = src_hit(id_use0, id_src0, ex_q.valid,  ex_q.we,  ex_q.dst);
  assign hit1_ex  = src_hit(id_use1, id_src1, ex_q.valid,  ex_q.we,  ex_q.dst);
  assign hit0_mem = src_hit(id_use0, id_src0, mem_q.valid, mem_q.we, mem_q.dst);
  assign hit1_mem = src_hit(id_use1, id_src1, mem_q.valid, mem_q.we, mem_q.dst);

  assign load_use    = id_valid && ex_q.valid && ex_q.load && ex_q.we && (hit0_ex || hit1_ex);
  assign stall_if    = mem_stall || load_use || hlt_seen_q;
  assign flush_if_id = branch_taken && !mem_stall;
  assign bubble_ex   = !mem_stall && (load_use || branch_taken || !id_valid);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    id_trk       = '0;
    id_trk.valid = id_valid;
    id_trk.dst   = id_dst;
    id_trk.we    = id_we;
    id_trk.load  = id_load;
    id_trk.hlt   = id_hlt;

    // Youngest producer wins: EX (moving to EX/MEM) over MEM (moving to MEM/WB).
    fwd0_nxt = FWD_RF;
    fwd1_nxt = FWD_RF;
    if (!bubble_ex) begin
      if (hit0_ex)       fwd0_nxt = FWD_EXMEM;
      else if (hit0_mem) fwd0_nxt = FWD_MEMWB;
      if (hit1_ex)       fwd1_nxt = FWD_EXMEM;
      else if (hit1_mem) fwd1_nxt = FWD_MEMWB;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_hlt_q   <= 1'b0;
      hlt_seen_q <= 1'b0;
      halted     <= 1'b0;
      fwd0_sel   <= FWD_RF;
      fwd1_sel   <= FWD_RF;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      if (!mem_stall) begin
        wb_hlt_q <= mem_q.valid && mem_q.hlt;

        if (branch_taken) begin
          mem_q <= '0;
        end else begin
          mem_q.valid <= ex_q.valid;
          mem_q.dst   <= ex_q.dst;
          mem_q.we    <= ex_q.we;
          mem_q.hlt   <= ex_q.hlt;
        end

        ex_q     <= bubble_ex ? '0 : id_trk;
        fwd0_sel <= fwd0_nxt;
        fwd1_sel <= fwd1_nxt;

        // A taken branch squashing an in-flight HLT releases fetch again.
        if (branch_taken && ex_q.valid && ex_q.hlt)
          hlt_seen_q <= 1'b0;
        else if (id_valid && id_hlt && !bubble_ex)
          hlt_seen_q <= 1'b1;

        // Flush wins over a coincident load-use: only the flush is counted.
        if (load_use && !branch_taken && stall_cnt != '1)
          stall_cnt <= stall_cnt + CNT_W'(1);
        if (flush_if_id && flush_cnt != '1)
          flush_cnt <= flush_cnt + CNT_W'(1);
      end

      if (wb_hlt_q)
        halted <= 1'b1;
    end
  end

endmodule
